// File: rtl/icon_pkg.sv
// Shared types and constants for the icon locator video monitor.
package icon_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF,
    SCAN,
    DIVIDE,
    HOLD
  } loc_state_t;

  // Display-to-world scaling: X is a shift, Y needs a true divide by 6.
  localparam int ROW_SCALE = 6;
  localparam int COL_SHIFT = 3;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int V_ACTIVE_DEF = 768;

  localparam int COORD_W = 12;
  localparam int COUNT_W = 11;
  localparam int LOC_W   = 8;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Saturating increment for the opaque-pixel counter.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/icon_locator_div.sv
// Sequential divide by a constant using repeated subtraction, one step per
// cycle, with a saturating quotient. A dividend already below the divisor
// finishes in the start cycle, so an N-step divide reports done N cycles
// after start.
module seq_div_const #(
  parameter int DIVISOR    = 6,
  parameter int DIVIDEND_W = 12,
  parameter int QUOT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  localparam logic [DIVIDEND_W-1:0] DIV  = DIVIDEND_W'(DIVISOR);
  localparam logic [QUOT_W-1:0]     QMAX = '1;

  logic [DIVIDEND_W-1:0] rem_q, rem_d;
  logic [QUOT_W-1:0]     quot_q, quot_d;
  logic                  busy_q, busy_d;

  // Next remainder/quotient and the done strobe for the current cycle.
  always_comb begin
    rem_d    = rem_q;
    quot_d   = quot_q;
    busy_d   = busy_q;
    done     = 1'b0;
    quotient = quot_q;
    if (start) begin
      if (dividend < DIV) begin
        done     = 1'b1;
        quotient = '0;
        busy_d   = 1'b0;
      end else begin
        rem_d  = dividend - DIV;
        quot_d = QUOT_W'(1);
        busy_d = 1'b1;
      end
    end else if (busy_q) begin
      if (rem_q < DIV) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end else begin
        rem_d  = rem_q - DIV;
        quot_d = (quot_q == QMAX) ? quot_q : quot_q + QUOT_W'(1);
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/icon_locator.sv
// Passive display-stream monitor: finds the bounding-box top-left of the
// opaque icon pixels in each frame and reports it in world coordinates.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   WAIT_SOF | idle, waiting for pixel (0,0) of a new frame
//   SCAN     | accumulating first-hit row, min column and hit count
//   DIVIDE   | converting min_row to world Y (row / 6)
//   HOLD     | report valid, waiting for loc_ready
module icon_locator
  import icon_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PIPE_DLY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pix_row,
  input  logic [COORD_W-1:0] pix_col,
  input  logic               video_on,
  input  logic [1:0]         icon_in,
  output logic               loc_valid,
  input  logic               loc_ready,
  output logic [LOC_W-1:0]   loc_X,
  output logic [LOC_W-1:0]   loc_Y,
  output logic [COUNT_W-1:0] pix_count,
  output logic               no_icon
);

  logic [COORD_W-1:0] d_row, d_col;
  logic               d_von;

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign d_row = pix_row;
      assign d_col = pix_col;
      assign d_von = video_on;
    end else begin : g_dly
      logic [COORD_W-1:0] row_q [PIPE_DLY];
      logic [COORD_W-1:0] col_q [PIPE_DLY];
      logic               von_q [PIPE_DLY];

      // Align coordinates with the icon ROM read latency.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            row_q[i] <= '0;
            col_q[i] <= '0;
            von_q[i] <= 1'b0;
          end
        end else begin
          row_q[0] <= pix_row;
          col_q[0] <= pix_col;
          von_q[0] <= video_on;
          for (int i = 1; i < PIPE_DLY; i++) begin
            row_q[i] <= row_q[i-1];
            col_q[i] <= col_q[i-1];
            von_q[i] <= von_q[i-1];
          end
        end
      end

      assign d_row = row_q[PIPE_DLY-1];
      assign d_col = col_q[PIPE_DLY-1];
      assign d_von = von_q[PIPE_DLY-1];
    end
  endgenerate

  loc_state_t state_q;

  logic               loc_valid_q, no_icon_q;
  logic [LOC_W-1:0]   loc_x_q, loc_y_q;
  logic [COUNT_W-1:0] pix_count_q;

  logic [COORD_W-1:0] min_row_q, min_row_d;
  logic [COORD_W-1:0] min_col_q, min_col_d;
  logic               any_hit_q, any_hit_d;
  logic [COUNT_W-1:0] hit_cnt_q, hit_cnt_d;

  logic sof, eof, hit, fresh, scanning;

  assign sof = d_von && (d_row == '0) && (d_col == '0);
  assign eof = d_von && (d_row == COORD_W'(V_ACTIVE - 1)) && (d_col == COORD_W'(H_ACTIVE - 1));
  assign hit = d_von && (icon_in != 2'b00);

  // The start-of-frame pixel is itself scanned, against freshly cleared
  // accumulators rather than last frame's leftovers.
  assign fresh    = (state_q == WAIT_SOF) && sof;
  assign scanning = fresh || (state_q == SCAN);

  // Accumulator update for the pixel currently presented.
  always_comb begin
    min_row_d = fresh ? '0     : min_row_q;
    min_col_d = fresh ? '1     : min_col_q;
    any_hit_d = fresh ? 1'b0   : any_hit_q;
    hit_cnt_d = fresh ? '0     : hit_cnt_q;
    if (hit) begin
      if (!any_hit_d) begin
        min_row_d = d_row;
      end
      if (d_col < min_col_d) begin
        min_col_d = d_col;
      end
      any_hit_d = 1'b1;
      hit_cnt_d = sat_inc(hit_cnt_d);
    end
  end

  logic             div_start, div_busy, div_done;
  logic [LOC_W-1:0] div_quot;

  assign div_start = scanning && eof && any_hit_d;

  seq_div_const #(
    .DIVISOR    (ROW_SCALE),
    .DIVIDEND_W (COORD_W),
    .QUOT_W     (LOC_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (min_row_d),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Frame sequencing, accumulators and registered report outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_SOF;
      loc_valid_q <= 1'b0;
      loc_x_q     <= '0;
      loc_y_q     <= '0;
      pix_count_q <= '0;
      no_icon_q   <= 1'b0;
      min_row_q   <= '0;
      min_col_q   <= '1;
      any_hit_q   <= 1'b0;
      hit_cnt_q   <= '0;
    end else begin
      case (state_q)
        WAIT_SOF, SCAN: begin
          if (scanning) begin
            min_row_q <= min_row_d;
            min_col_q <= min_col_d;
            any_hit_q <= any_hit_d;
            hit_cnt_q <= hit_cnt_d;
            if (eof) begin
              if (!any_hit_d) begin
                state_q     <= HOLD;
                loc_valid_q <= 1'b1;
                no_icon_q   <= 1'b1;
                loc_x_q     <= '0;
                loc_y_q     <= '0;
                pix_count_q <= '0;
              end else if (div_done) begin
                // First hit in rows 0..5: quotient is ready without stepping.
                state_q     <= HOLD;
                loc_valid_q <= 1'b1;
                no_icon_q   <= 1'b0;
                loc_x_q     <= LOC_W'(min_col_d >> COL_SHIFT);
                loc_y_q     <= div_quot;
                pix_count_q <= hit_cnt_d;
              end else begin
                state_q <= DIVIDE;
              end
            end else begin
              state_q <= SCAN;
            end
          end
        end
        DIVIDE: begin
          if (div_done) begin
            state_q     <= HOLD;
            loc_valid_q <= 1'b1;
            no_icon_q   <= 1'b0;
            loc_x_q     <= LOC_W'(min_col_q >> COL_SHIFT);
            loc_y_q     <= div_quot;
            pix_count_q <= hit_cnt_q;
          end else if (!div_busy) begin
            // Divider lost its job; abandon this frame rather than hang.
            state_q <= WAIT_SOF;
          end
        end
        HOLD: begin
          if (loc_ready) begin
            state_q     <= WAIT_SOF;
            loc_valid_q <= 1'b0;
          end
        end
        default: state_q <= WAIT_SOF;
      endcase
    end
  end

  assign loc_valid = loc_valid_q;
  assign loc_X     = loc_x_q;
  assign loc_Y     = loc_y_q;
  assign pix_count = pix_count_q;
  assign no_icon   = no_icon_q;

endmodule

// File: tb/tb_icon_locator.sv
// Testbench for icon_locator: sparse synthetic frames (SOF, pixels of
// interest, last pixel), a frame-level reference model checked every cycle,
// plus literal expectations for hand-computed scenarios.
module tb_icon_locator;

  localparam int H   = 1024;
  localparam int V   = 768;
  localparam int DLY = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pix_row = '0, pix_col = '0;
  logic        video_on = 1'b0;
  logic [1:0]  icon_in = '0;
  logic        loc_ready = 1'b0;
  logic        loc_valid;
  logic [7:0]  loc_X, loc_Y;
  logic [10:0] pix_count;
  logic        no_icon;

  icon_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .PIPE_DLY(DLY)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .video_on  (video_on),
    .icon_in   (icon_in),
    .loc_valid (loc_valid),
    .loc_ready (loc_ready),
    .loc_X     (loc_X),
    .loc_Y     (loc_Y),
    .pix_count (pix_count),
    .no_icon   (no_icon)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int         row;
    int         col;
    bit         von;
    logic [1:0] icon;
    bit         rst;
  } pix_t;

  pix_t       frm[$];
  logic [1:0] icon_hist[4] = '{default: 2'b00};
  int         last_cyc = 0;

  // One pixel per cycle; the icon colour trails its coordinates by DLY cycles.
  task automatic drive(input int row, input int col, input bit von,
                       input logic [1:0] icon, input bit rst);
    @(posedge clk);
    #1;
    pix_row  = row[11:0];
    pix_col  = col[11:0];
    video_on = von;
    reset    = rst;
    icon_in  = (DLY == 0) ? icon : icon_hist[DLY-1];
    for (int i = 3; i > 0; i--) icon_hist[i] = icon_hist[i-1];
    icon_hist[0] = icon;
    if (rnd_ready) loc_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0, 2'b00, 1'b0);
  endtask

  function automatic void fstart(input logic [1:0] ic);
    frm.delete();
    frm.push_back('{0, 0, 1'b1, ic, 1'b0});
  endfunction

  function automatic void fpix(input int r, input int c, input logic [1:0] ic);
    frm.push_back('{r, c, 1'b1, ic, 1'b0});
  endfunction

  function automatic void fend();
    frm.push_back('{V-1, H-1, 1'b1, 2'b00, 1'b0});
  endfunction

  task automatic send_frame();
    foreach (frm[i]) drive(frm[i].row, frm[i].col, frm[i].von, frm[i].icon, frm[i].rst);
    last_cyc = cyc;
  endtask

  // ---------------- report monitor ----------------
  typedef struct {
    int x, y, cnt, no, run, at;
  } got_t;

  got_t got[$];
  int   run = 0;

  always @(negedge clk) begin
    if (loc_valid) begin
      run++;
      if (loc_ready) begin
        got_t g;
        g.x = int'(loc_X); g.y = int'(loc_Y); g.cnt = int'(pix_count);
        g.no = int'(no_icon); g.run = run; g.at = cyc;
        got.push_back(g);
        run = 0;
      end
    end else begin
      run = 0;
    end
  end

  task automatic wait_rep(input string name, input int limit, output got_t g);
    int n = 0;
    while (got.size() == 0 && n < limit) begin
      blank(1);
      n++;
    end
    check({name, ".arrived"}, int'(got.size() > 0), 1);
    if (got.size() > 0) g = got.pop_front();
    else g = '{-1, -1, -1, -1, -1, -1};
  endtask

  task automatic expect_rep(input string name, input int limit,
                            input int x, input int y, input int cnt, input int no,
                            input int latency);
    got_t g;
    wait_rep(name, limit, g);
    check({name, ".loc_X"}, g.x, x);
    check({name, ".loc_Y"}, g.y, y);
    check({name, ".pix_count"}, g.cnt, cnt);
    check({name, ".no_icon"}, g.no, no);
    if (latency >= 0) check({name, ".latency"}, g.at - last_cyc, latency);
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: a frame is captured only if it starts while no report
  // is outstanding; its report appears 1 + floor(first_row/6) cycles after
  // the last pixel and is held until loc_ready is seen.
  typedef struct {
    int row, col;
  } hit_t;

  localparam int M_IDLE = 0, M_CAP = 1, M_COMP = 2, M_REP = 3;

  hit_t hits[$];
  int   mode = M_IDLE;
  int   countdown = 0;
  int   e_x = 0, e_y = 0, e_cnt = 0;
  bit   e_no = 0, e_valid = 0;
  int   p_x, p_y, p_cnt;
  int   h_row[4] = '{default: 0};
  int   h_col[4] = '{default: 0};
  bit   h_von[4] = '{default: 1'b0};

  always @(negedge clk) begin : model
    int  drow, dcol, minc, steps;
    bit  dvon;
    vectors++;
    if ({loc_valid, loc_X, loc_Y, pix_count, no_icon} !==
        {e_valid, 8'(e_x), 8'(e_y), 11'(e_cnt), e_no}) begin
      miscompares++;
      $display("FAIL outputs @%0d: got v=%0d X=%0d Y=%0d cnt=%0d no=%0d, expected v=%0d X=%0d Y=%0d cnt=%0d no=%0d",
               cyc, loc_valid, loc_X, loc_Y, pix_count, no_icon,
               e_valid, e_x, e_y, e_cnt, e_no);
    end

    if (DLY == 0) begin
      drow = int'(pix_row); dcol = int'(pix_col); dvon = video_on;
    end else begin
      drow = h_row[DLY-1]; dcol = h_col[DLY-1]; dvon = h_von[DLY-1];
    end

    if (reset) begin
      e_x = 0; e_y = 0; e_cnt = 0; e_no = 0; e_valid = 0;
      mode = M_IDLE;
      hits.delete();
      h_row = '{default: 0}; h_col = '{default: 0}; h_von = '{default: 1'b0};
    end else begin
      if (mode == M_REP) begin
        if (loc_ready) begin
          e_valid = 0;
          mode = M_IDLE;
        end
      end else if (mode == M_COMP) begin
        countdown--;
        if (countdown == 0) begin
          e_x = p_x; e_y = p_y; e_cnt = p_cnt; e_no = 0; e_valid = 1;
          mode = M_REP;
        end
      end else begin
        if (mode == M_IDLE && dvon && drow == 0 && dcol == 0) begin
          mode = M_CAP;
          hits.delete();
        end
        if (mode == M_CAP) begin
          if (dvon && icon_in != 2'b00) hits.push_back('{drow, dcol});
          if (dvon && drow == V-1 && dcol == H-1) begin
            if (hits.size() == 0) begin
              e_x = 0; e_y = 0; e_cnt = 0; e_no = 1; e_valid = 1;
              mode = M_REP;
            end else begin
              minc = 4095;
              foreach (hits[i]) if (hits[i].col < minc) minc = hits[i].col;
              steps = hits[0].row / 6;
              p_x   = minc / 8;
              p_y   = (steps > 255) ? 255 : steps;
              p_cnt = (hits.size() > 2047) ? 2047 : hits.size();
              if (steps == 0) begin
                e_x = p_x; e_y = p_y; e_cnt = p_cnt; e_no = 0; e_valid = 1;
                mode = M_REP;
              end else begin
                countdown = steps;
                mode = M_COMP;
              end
            end
          end
        end
      end
      for (int i = 3; i > 0; i--) begin
        h_row[i] = h_row[i-1]; h_col[i] = h_col[i-1]; h_von[i] = h_von[i-1];
      end
      h_row[0] = int'(pix_row); h_col[0] = int'(pix_col); h_von[0] = video_on;
    end
  end

  // ---------------- random frames ----------------
  task automatic rand_frame();
    int r, h, w, c0, nrect;
    fstart(($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00);
    nrect = $urandom_range(0, 3);
    r = $urandom_range(0, 200);
    for (int k = 0; k < nrect; k++) begin
      h  = $urandom_range(1, 6);
      w  = $urandom_range(1, 10);
      c0 = $urandom_range(0, 1013);
      for (int rr = r; rr < r + h; rr++) begin
        for (int cc = c0; cc < c0 + w; cc++) begin
          fpix(rr, cc, 2'($urandom_range(0, 3)));
          if ($urandom_range(0, 15) == 0)
            frm.push_back('{$urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, 2'b11, 1'b0});
        end
      end
      r = r + h + $urandom_range(0, 100);
    end
    fend();
    if ($urandom_range(0, 11) == 0) frm[$urandom_range(0, frm.size() - 1)].rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 3; i++) drive(0, 0, 1'b0, 2'b00, 1'b1);
    blank(1);
    check("reset.loc_valid", int'(loc_valid), 0);
    check("reset.loc_X", int'(loc_X), 0);
    check("reset.loc_Y", int'(loc_Y), 0);
    check("reset.pix_count", int'(pix_count), 0);
    check("reset.no_icon", int'(no_icon), 0);

    // Full 32x32 icon at (120,80).
    loc_ready = 1'b1;
    fstart(2'b00);
    for (int r = 120; r < 152; r++)
      for (int c = 80; c < 112; c++) fpix(r, c, 2'($urandom_range(1, 3)));
    fend();
    send_frame();
    expect_rep("icon32", 200, 10, 20, 1024, 0, DLY + 1 + 20);
    blank(10);

    // Frame with no opaque pixel.
    fstart(2'b00);
    for (int i = 0; i < 20; i++) fpix($urandom_range(1, 700), $urandom_range(0, 1023), 2'b00);
    fend();
    send_frame();
    expect_rep("empty", 50, 0, 0, 0, 1, DLY + 1);
    blank(10);

    // Tilted icon: top row hit is not the leftmost column.
    fstart(2'b00);
    fpix(300, 500, 2'b10);
    fpix(305, 495, 2'b00);
    fpix(310, 488, 2'b01);
    fend();
    send_frame();
    expect_rep("tilted", 200, 61, 50, 2, 0, DLY + 1 + 50);
    blank(10);

    // Consumer stalls for three frames, then one ready pulse.
    loc_ready = 1'b0;
    fstart(2'b00); fpix(60, 40, 2'b11); fend();
    send_frame();
    for (int f = 0; f < 3; f++) begin
      blank(40);
      fstart(2'b00); fpix(200 + f, 300 + f, 2'b01); fpix(220, 10, 2'b01); fend();
      send_frame();
    end
    blank(20);
    check("stall.no_early_transfer", got.size(), 0);
    loc_ready = 1'b1;
    blank(1);
    loc_ready = 1'b0;
    blank(5);
    expect_rep("stall.A", 5, 5, 10, 1, 0, -1);
    loc_ready = 1'b1;
    fstart(2'b00); fpix(90, 200, 2'b10); fpix(91, 199, 2'b10); fend();
    send_frame();
    expect_rep("stall.B", 100, 24, 15, 2, 0, DLY + 1 + 15);
    blank(10);

    // Reset in the middle of a long divide.
    fstart(2'b00); fpix(762, 100, 2'b01); fend();
    send_frame();
    blank(30);
    drive(0, 0, 1'b0, 2'b00, 1'b1);
    blank(1);
    check("middiv.loc_valid", int'(loc_valid), 0);
    blank(200);
    check("middiv.no_report", got.size(), 0);
    fstart(2'b00); fpix(762, 100, 2'b01); fend();
    send_frame();
    expect_rep("row762", 300, 12, 127, 1, 0, DLY + 1 + 127);
    blank(10);

    // Single hit on the start-of-frame pixel, ready held high.
    begin
      got_t g;
      fstart(2'b01); fend();
      send_frame();
      wait_rep("origin", 20, g);
      check("origin.loc_X", g.x, 0);
      check("origin.loc_Y", g.y, 0);
      check("origin.pix_count", g.cnt, 1);
      check("origin.valid_cycles", g.run, 1);
      check("origin.latency", g.at - last_cyc, DLY + 1);
    end
    blank(10);

    // Counter saturation: 2100 opaque pixels.
    fstart(2'b00);
    for (int r = 10; r < 52; r++)
      for (int c = 0; c < 50; c++) fpix(r, c, 2'b11);
    fend();
    send_frame();
    expect_rep("saturate", 50, 0, 1, 2047, 0, DLY + 1 + 1);
    blank(10);

    // Randomized frames, gaps, consumer stalls and occasional resets.
    rnd_ready = 1'b1;
    for (int f = 0; f < 60; f++) begin
      rand_frame();
      send_frame();
      blank($urandom_range(0, 400));
    end
    rnd_ready = 1'b0;
    loc_ready = 1'b1;
    blank(700);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
